led_hit_scorer: RTL and testbench



---
 rtl/led_hit_scorer.sv | 111 +++++++++++
 tb/tb_led_hit_scorer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/led_hit_scorer.sv
// Reaction-game scorer: classifies button presses against lit LEDs, keeps a saturating
// score and a millisecond reaction timer. Define LED_HIT_SCORER_MISS_PENALTY_EN to let misses cost a point.
module led_hit_scorer #(
  parameter int N_LEDS      = 8,
  parameter int CLKS_PER_MS = 50000,
  parameter int MAX_SCORE   = 999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led,
  input  logic [N_LEDS-1:0] button,
  output logic [9:0]        score,
  output logic              hit,
  output logic              miss,
  output logic [10:0]       reaction_ms
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int CW = $clog2(N_LEDS + 1);
  localparam logic signed [11:0] MAX_S = 12'(MAX_SCORE);

  logic [N_LEDS-1:0] r_btn_q;
  logic [N_LEDS-1:0] r_led_q;
  logic [N_LEDS-1:0] r_scored;
  logic              r_armed;
  logic [PW-1:0]     r_presc;
  logic [10:0]       r_ms;

  logic [N_LEDS-1:0] w_press;
  logic [N_LEDS-1:0] w_rise;
  logic [N_LEDS-1:0] w_hit_lane;
  logic [N_LEDS-1:0] w_miss_lane;
  logic [CW-1:0]     w_hit_cnt;
  logic [CW-1:0]     w_miss_cnt;
  logic [CW-1:0]     w_pen_cnt;
  logic signed [11:0] w_sum;
  logic [9:0]        w_score_n;
  logic              w_wrap;

  // r_armed masks presses on the first cycle after reset, so a button held
  // through reset release is absorbed into r_btn_q instead of counting as an edge.
  assign w_press     = button & ~r_btn_q & {N_LEDS{r_armed}};
  assign w_rise      = led & ~r_led_q;
  assign w_hit_lane  = w_press & led & (~r_scored | w_rise);
  assign w_miss_lane = w_press & ~led;
  assign w_wrap      = (r_presc == PW'(CLKS_PER_MS - 1));

  always_comb begin
    w_hit_cnt  = '0;
    w_miss_cnt = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_hit_cnt  = w_hit_cnt + CW'(w_hit_lane[i]);
      w_miss_cnt = w_miss_cnt + CW'(w_miss_lane[i]);
    end
  end

`ifdef LED_HIT_SCORER_MISS_PENALTY_EN
  assign w_pen_cnt = w_miss_cnt;
`else
  assign w_pen_cnt = '0;
`endif

  always_comb begin
    w_sum = $signed({2'b00, score})
          + $signed({{(12-CW){1'b0}}, w_hit_cnt})
          - $signed({{(12-CW){1'b0}}, w_pen_cnt});
    if (w_sum < 12'sd0)
      w_score_n = '0;
    else if (w_sum > MAX_S)
      w_score_n = 10'(MAX_SCORE);
    else
      w_score_n = w_sum[9:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_q     <= '0;
      r_led_q     <= '0;
      r_scored    <= '0;
      r_armed     <= 1'b0;
      r_presc     <= '0;
      r_ms        <= '0;
      score       <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      reaction_ms <= '0;
    end else begin
      r_btn_q  <= button;
      r_led_q  <= led;
      r_armed  <= 1'b1;
      // A hit wins over the rise/unlit clear so a same-cycle rise+press stays scored.
      r_scored <= w_hit_lane | (r_scored & led & ~w_rise);
      if (|w_rise) begin
        r_presc <= '0;
        r_ms    <= '0;
      end else if (w_wrap) begin
        r_presc <= '0;
        if (r_ms != 11'h7FF)
          r_ms <= r_ms + 11'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      score <= w_score_n;
      hit   <= |w_hit_lane;
      miss  <= |w_miss_lane;
      if (|w_hit_lane)
        reaction_ms <= r_ms;
    end
  end

endmodule

// File: tb/tb_led_hit_scorer.sv
// Directed bench for led_hit_scorer with a scoreboard queue of expected outputs.
module tb_led_hit_scorer;

  localparam int CPM = 20;
`ifdef LED_HIT_SCORER_MISS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  led_i;
  logic [7:0]  button_i;
  logic [9:0]  score;
  logic        hit;
  logic        miss;
  logic [10:0] reaction_ms;

  typedef struct {
    logic        h;
    logic        m;
    logic [9:0]  s;
    logic [10:0] r;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_s;

  led_hit_scorer #(.N_LEDS(8), .CLKS_PER_MS(CPM), .MAX_SCORE(999)) dut (
    .clk(clk), .reset(reset), .led(led_i), .button(button_i),
    .score(score), .hit(hit), .miss(miss), .reaction_ms(reaction_ms)
  );

  always #5 clk = ~clk;

  task automatic ex(input logic h, input logic m, input int s, input int r, input string tag);
    exp_t e;
    e.h = h; e.m = m; e.s = 10'(s); e.r = 11'(r); e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input logic [7:0] l, input logic [7:0] b);
    exp_t e;
    led_i = l;
    button_i = b;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      assert ({hit, miss, score, reaction_ms} === {e.h, e.m, e.s, e.r})
      else begin
        fails++;
        $error("FAIL %s: got hit=%0d miss=%0d score=%0d rms=%0d, expected hit=%0d miss=%0d score=%0d rms=%0d",
               e.tag, hit, miss, score, reaction_ms, e.h, e.m, e.s, e.r);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    led_i = '0;
    button_i = '0;
    tick(8'h00, 8'h00);
    ex(0, 0, 0, 0, "reset_state");
    tick(8'h00, 8'h00);
    reset = 1'b0;
    tick(8'h00, 8'h00);

    // First hit, 3 ms after the LED rise
    tick(8'h04, 8'h00);
    for (int i = 0; i < 3 * CPM; i++) tick(8'h04, 8'h00);
    ex(1, 0, 1, 3, "first_hit");
    tick(8'h04, 8'h04);
    ex(0, 0, 1, 3, "hit_one_cycle");
    tick(8'h04, 8'h04);
    for (int i = 0; i < 98; i++) tick(8'h04, 8'h04);
    ex(0, 0, 1, 3, "hold_no_repress");
    tick(8'h04, 8'h00);
    ex(0, 0, 1, 3, "second_press_ignored");
    tick(8'h04, 8'h04);
    tick(8'h04, 8'h00);

    // Misses on an unlit lane
    exp_s = 1;
    tick(8'h00, 8'h00);
    exp_s = PEN ? 0 : 1;
    ex(0, 1, exp_s, 3, "miss_1");
    tick(8'h00, 8'h20);
    tick(8'h00, 8'h00);
    ex(0, 1, exp_s, 3, "miss_at_floor");
    tick(8'h00, 8'h20);
    tick(8'h00, 8'h00);

    // Simultaneous hit and miss
    tick(8'h01, 8'h00);
    exp_s = PEN ? exp_s : exp_s + 1;
    ex(1, 1, exp_s, 0, "hit_and_miss");
    tick(8'h01, 8'h03);
    tick(8'h00, 8'h00);

    // Climb to 998 with 8-lane rounds, then a partial round
    while (exp_s + 8 <= 998) begin
      tick(8'h00, 8'h00);
      tick(8'hFF, 8'hFF);
      exp_s += 8;
    end
    if (exp_s < 998) begin
      tick(8'h00, 8'h00);
      ex(1, 0, 998, 0, "preload_998");
      tick(8'hFF, 8'((1 << (998 - exp_s)) - 1));
      exp_s = 998;
    end
    tick(8'h00, 8'h00);
    ex(1, 0, 999, 0, "saturate_999");
    tick(8'hFF, 8'hFF);
    ex(0, 0, 999, 0, "sat_single_pulse");
    tick(8'hFF, 8'h00);
    tick(8'h00, 8'h00);
    ex(1, 0, 999, 0, "hit_at_max");
    tick(8'hFF, 8'hFF);

    // Reset while score is 7 and button 3 is held
    reset = 1'b1;
    tick(8'h00, 8'h00);
    reset = 1'b0;
    tick(8'h00, 8'h00);
    ex(1, 0, 7, 0, "seven_hits");
    tick(8'h7F, 8'h7F);
    ex(0, 0, 7, 0, "hold_b3");
    tick(8'h08, 8'h08);
    reset = 1'b1;
    ex(0, 0, 0, 0, "mid_reset");
    tick(8'h08, 8'h08);
    reset = 1'b0;
    ex(0, 0, 0, 0, "held_through_release");
    tick(8'h08, 8'h08);
    ex(0, 0, 0, 0, "held_after_release");
    tick(8'h08, 8'h08);
    ex(0, 0, 0, 0, "released");
    tick(8'h08, 8'h00);
    ex(1, 0, 1, 0, "repress_after_reset");
    tick(8'h08, 8'h08);

    tick(8'h00, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
